// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared constants and encodings for the MIPS instruction fetch stage
package mips_fetch_pkg;
  localparam int NB_DATA         = 32;
  localparam int NB_JUMP_ADDRESS = 26;
  localparam int NB_OP_FIELD     = 6;
  localparam int NB_MEM_ADDRESS  = 8;
  localparam logic [NB_OP_FIELD-1:0] HALT_OPCODE = 6'b111111;
  localparam logic [NB_DATA-1:0]     INSTR_NOP   = '0;
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_src_e;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: control, redirect, debug-load and IF/ID signals of the fetch stage
interface instruction_fetch_if;
  import mips_fetch_pkg::*;
  logic                       i_enable;
  logic                       i_stall;
  logic                       i_flush;
  logic [1:0]                 i_pc_source;
  logic [NB_DATA-1:0]         i_dato_direc_branch;
  logic [NB_JUMP_ADDRESS-1:0] i_dato_direc_jump;
  logic [NB_DATA-1:0]         i_dato_ra;
  logic                       i_mem_write_enable;
  logic [NB_MEM_ADDRESS-1:0]  i_mem_write_address;
  logic [NB_DATA-1:0]         i_mem_write_data;
  logic [NB_DATA-1:0]         o_instruccion;
  logic [NB_DATA-1:0]         o_pc_plus4;
  logic [NB_DATA-1:0]         o_pc;
  logic                       o_halt;
  modport master (
    output i_enable, i_stall, i_flush, i_pc_source, i_dato_direc_branch, i_dato_direc_jump,
           i_dato_ra, i_mem_write_enable, i_mem_write_address, i_mem_write_data,
    input  o_instruccion, o_pc_plus4, o_pc, o_halt
  );
  modport slave (
    input  i_enable, i_stall, i_flush, i_pc_source, i_dato_direc_branch, i_dato_direc_jump,
           i_dato_ra, i_mem_write_enable, i_mem_write_address, i_mem_write_data,
    output o_instruccion, o_pc_plus4, o_pc, o_halt
  );
endinterface

// File: rtl/instruction_memory.sv
// instruction_memory: word array with one synchronous write port and one asynchronous read port
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clock,
  input  logic               i_write_enable,
  input  logic [NB_ADDR-1:0] i_write_address,
  input  logic [NB_DATA-1:0] i_write_data,
  input  logic [NB_ADDR-1:0] i_read_address,
  output logic [NB_DATA-1:0] o_read_data
);
  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
  always_ff @(posedge i_clock) begin
    if (i_write_enable) mem_q[i_write_address] <= i_write_data;
  end
  assign o_read_data = mem_q[i_read_address];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage - PC, next-PC select, instruction memory and IF/ID register
module instruction_fetch
  import mips_fetch_pkg::*;
(
  input logic          i_clock,
  input logic          i_reset,
  instruction_fetch_if.slave bus
);
  logic [NB_DATA-1:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic [NB_DATA-1:0] pc_plus4, fetch, target;
  logic               halt_q, halt_d;
  instruction_memory #(.NB_DATA(NB_DATA), .NB_ADDR(NB_MEM_ADDRESS)) u_imem (
    .i_clock        (i_clock),
    .i_write_enable (bus.i_mem_write_enable),
    .i_write_address(bus.i_mem_write_address),
    .i_write_data   (bus.i_mem_write_data),
    .i_read_address (pc_q[NB_MEM_ADDRESS+1:2]),
    .o_read_data    (fetch)
  );
  assign pc_plus4 = pc_q + NB_DATA'(4);
  // Redirect targets are relative to the instruction sitting in ID, hence pc4_q
  always_comb begin
    target = bus.i_pc_source == PC_BRANCH ? pc4_q + (bus.i_dato_direc_branch << 2) :
             bus.i_pc_source == PC_JUMP   ? {pc4_q[NB_DATA-1 -: 4], bus.i_dato_direc_jump, 2'b00} :
             bus.i_pc_source == PC_JR     ? bus.i_dato_ra : pc_plus4;
  end
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    halt_d  = halt_q;
    if (bus.i_enable && !bus.i_stall) begin
      if (bus.i_flush) begin
        pc_d    = target;
        instr_d = INSTR_NOP;
        pc4_d   = '0;
      end else if (halt_q) begin
        instr_d = INSTR_NOP;
      end else begin
        pc_d    = pc_plus4;
        instr_d = fetch;
        pc4_d   = pc_plus4;
        halt_d  = fetch[NB_DATA-1 -: NB_OP_FIELD] == HALT_OPCODE;
      end
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q    <= '0;
      instr_q <= INSTR_NOP;
      pc4_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      halt_q  <= halt_d;
    end
  end
  assign bus.o_instruccion = instr_q;
  assign bus.o_pc_plus4    = pc4_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_halt        = halt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vectors plus randomized run against a behavioural fetch model
module tb_instruction_fetch;
  import mips_fetch_pkg::*;
  logic clk = 1'b0;
  logic rst;
  instruction_fetch_if bus();
  instruction_fetch dut (.i_clock(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_halt;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        halt;
  } vec_t;
  vec_t tv [5];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  // One clock edge: advance the reference model from the current inputs, then compare
  task automatic tick(string tag);
    logic [31:0] word, nxt;
    word = m_mem[m_pc[9:2]];
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_halt = 0;
    end else if (bus.i_enable && !bus.i_stall) begin
      if (bus.i_flush) begin
        case (bus.i_pc_source)
          2'd1:    nxt = m_pc4 + bus.i_dato_direc_branch * 4;
          2'd2:    nxt = (m_pc4 & 32'hF000_0000) | ({6'd0, bus.i_dato_direc_jump} * 4);
          2'd3:    nxt = bus.i_dato_ra;
          default: nxt = m_pc + 4;
        endcase
        m_pc = nxt; m_instr = 0; m_pc4 = 0;
      end else if (m_halt) begin
        m_instr = 0;
      end else begin
        m_instr = word;
        m_pc = m_pc + 4;
        m_pc4 = m_pc;
        m_halt = (word >> 26) == 32'd63;
      end
    end
    if (bus.i_mem_write_enable) m_mem[bus.i_mem_write_address] = bus.i_mem_write_data;
    @(posedge clk);
    #1;
    check({tag, "_instr"}, bus.o_instruccion, m_instr);
    check({tag, "_pc4"}, bus.o_pc_plus4, m_pc4);
    check({tag, "_pc"}, bus.o_pc, m_pc);
    check({tag, "_halt"}, 32'(bus.o_halt), 32'(m_halt));
  endtask
  task automatic wr(logic [7:0] a, logic [31:0] d);
    bus.i_enable = 0; bus.i_mem_write_enable = 1;
    bus.i_mem_write_address = a; bus.i_mem_write_data = d;
    tick("wr");
    bus.i_mem_write_enable = 0; bus.i_enable = 1;
  endtask
  initial begin
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_halt = 0;
    rst = 1;
    bus.i_enable = 0; bus.i_stall = 0; bus.i_flush = 0; bus.i_pc_source = 0;
    bus.i_dato_direc_branch = 0; bus.i_dato_direc_jump = 0; bus.i_dato_ra = 0;
    bus.i_mem_write_enable = 1; bus.i_mem_write_address = 0; bus.i_mem_write_data = 0;
    for (int i = 0; i < 256; i++) begin
      bus.i_mem_write_address = 8'(i);
      bus.i_mem_write_data = i == 0 ? 32'h2001_0005 : i == 1 ? 32'h2002_0007 :
                             i == 2 ? 32'hFC00_0000 : 32'h0000_1000 + 32'(i);
      tick("load");
    end
    bus.i_mem_write_enable = 0;
    check("rst_instr", bus.o_instruccion, 32'h0);
    check("rst_pc", bus.o_pc, 32'h0);
    check("rst_halt", 32'(bus.o_halt), 32'h0);
    tv[0] = '{32'h2001_0005, 32'd4, 32'd4, 1'b0};
    tv[1] = '{32'h2002_0007, 32'd8, 32'd8, 1'b0};
    tv[2] = '{32'hFC00_0000, 32'd12, 32'd12, 1'b1};
    tv[3] = '{32'h0, 32'd12, 32'd12, 1'b1};
    tv[4] = '{32'h0, 32'd12, 32'd12, 1'b1};
    rst = 0; bus.i_enable = 1;
    for (int i = 0; i < 5; i++) begin
      tick("prog");
      check("tv_instr", bus.o_instruccion, tv[i].instr);
      check("tv_pc4", bus.o_pc_plus4, tv[i].pc4);
      check("tv_pc", bus.o_pc, tv[i].pc);
      check("tv_halt", 32'(bus.o_halt), 32'(tv[i].halt));
    end
    // stall at PC=8
    wr(8'd2, 32'h2003_0009);
    rst = 1; tick("rst2"); rst = 0;
    tick("run"); tick("run");
    check("pre_stall_pc", bus.o_pc, 32'd8);
    bus.i_stall = 1;
    tick("stall"); tick("stall");
    check("stall_pc", bus.o_pc, 32'd8);
    check("stall_instr", bus.o_instruccion, 32'h2002_0007);
    bus.i_stall = 0;
    tick("resume");
    check("resume_instr", bus.o_instruccion, 32'h2003_0009);
    tick("run");
    check("pre_br_pc4", bus.o_pc_plus4, 32'h10);
    // branch, jump, jump-register redirects
    bus.i_flush = 1; bus.i_pc_source = 2'b01; bus.i_dato_direc_branch = 32'hFFFF_FFFE;
    tick("br");
    check("br_pc", bus.o_pc, 32'h8);
    check("br_bubble", bus.o_instruccion, 32'h0);
    bus.i_flush = 0;
    tick("br_next");
    check("br_next_instr", bus.o_instruccion, 32'h2003_0009);
    bus.i_flush = 1; bus.i_pc_source = 2'b10; bus.i_dato_direc_jump = 26'h40;
    tick("j");
    check("j_pc", bus.o_pc, 32'h100);
    bus.i_pc_source = 2'b11; bus.i_dato_ra = 32'h24;
    tick("jr");
    check("jr_pc", bus.o_pc, 32'h24);
    check("jr_bubble", bus.o_instruccion, 32'h0);
    bus.i_flush = 0;
    tick("jr_next");
    check("jr_next_instr", bus.o_instruccion, 32'h0000_1009);
    // HALT on the wrong path, then stall+flush together
    wr(8'd10, 32'hFC00_0000);
    bus.i_flush = 1; bus.i_dato_ra = 32'h40;
    tick("halt_flush");
    check("wrongpath_halt", 32'(bus.o_halt), 32'h0);
    bus.i_flush = 0;
    tick("after_flush");
    check("after_flush_instr", bus.o_instruccion, 32'h0000_1010);
    bus.i_stall = 1; bus.i_flush = 1; bus.i_dato_ra = 32'h28;
    tick("stall_flush");
    check("stall_flush_pc", bus.o_pc, 32'h44);
    bus.i_stall = 0;
    tick("flush_late");
    bus.i_flush = 0;
    tick("halt");
    check("halt_set", 32'(bus.o_halt), 32'h1);
    tick("drain");
    check("drain_pc", bus.o_pc, 32'h2C);
    // reset while halted, load during disable, same-cycle write/read
    rst = 1; tick("rst3"); rst = 0;
    check("rst3_halt", 32'(bus.o_halt), 32'h0);
    wr(8'd0, 32'h1234_5678);
    tick("reload");
    check("reload_instr", bus.o_instruccion, 32'h1234_5678);
    bus.i_mem_write_enable = 1; bus.i_mem_write_address = 8'd1; bus.i_mem_write_data = 32'hAAAA_0001;
    tick("wr_rd");
    check("wr_rd_old", bus.o_instruccion, 32'h2002_0007);
    bus.i_mem_write_enable = 0;
    // randomized run
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 50) == 0;
      bus.i_enable = ($urandom % 10) != 0;
      bus.i_stall = ($urandom % 6) == 0;
      bus.i_flush = ($urandom % 5) == 0;
      bus.i_pc_source = 2'($urandom);
      bus.i_dato_direc_branch = 32'($urandom_range(0, 63)) - 32'd32;
      bus.i_dato_direc_jump = 26'($urandom_range(0, 255));
      bus.i_dato_ra = 32'($urandom_range(0, 1023));
      bus.i_mem_write_enable = ($urandom % 4) == 0;
      bus.i_mem_write_address = 8'($urandom);
      bus.i_mem_write_data = ($urandom % 16) == 0 ? 32'hFC00_0000 : {6'd0, 26'($urandom)};
      tick("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
